// File: rtl/rr_stream_mux_pkg.sv
// Shared constants for the round-robin / fixed-select stream mux.
package rr_stream_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   DEF_WIDTH  = 8;
    localparam int   DEF_NCH    = 4;
endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational rotating-priority arbiter: search starts one past ptr, wrapping modulo NCH.
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx
);
    logic found;

    // Outer loop walks priority order; inner loop keeps every index constant.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!found && (i == (int'(ptr) + k) % NCH) && req[i]) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end
    end
endmodule

// File: rtl/rr_stream_mux.sv
// NCH:1 valid/ready stream mux with fixed or round-robin select and a one-entry output register.
module rr_stream_mux
    import rr_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam logic [SELW-1:0] PTR_RST = SELW'(NCH - 1);

    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   rr_gnt, fx_gnt, gnt;
    logic [SELW-1:0]  rr_idx, gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en, xfer;

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Matching sel against every channel index means sel >= NCH simply never hits.
    always_comb begin
        fx_gnt = '0;
        for (int i = 0; i < NCH; i++)
            if (sel == SELW'(i)) fx_gnt[i] = in_valid[i];
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++)
            if (gnt[i]) gnt_data = in_data[i*WIDTH +: WIDTH];
    end

    assign gnt      = (mode == MODE_RR) ? rr_gnt : fx_gnt;
    assign gnt_idx  = (mode == MODE_RR) ? rr_idx : sel;
    assign load_en  = !out_valid | out_ready;
    assign in_ready = (load_en && !rst) ? gnt : '0;
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= PTR_RST;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
            if (mode == MODE_RR) ptr <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a 4-channel instance plus a 3-channel instance for wrap/odd-NCH cases.
module tb_rr_stream_mux;
    logic        clk = 1'b0;
    logic        rst = 1'b1, mode = 1'b0, out_ready = 1'b0;
    logic [1:0]  sel = '0;
    logic [31:0] in_data = 32'h33221100;
    logic [3:0]  in_valid = '0, in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;

    logic        c_rst = 1'b1, c_mode = 1'b0, c_out_ready = 1'b0;
    logic [1:0]  c_sel = '0;
    logic [23:0] c_in_data = 24'hC2B1A0;
    logic [2:0]  c_in_valid = '0, c_in_ready;
    logic [7:0]  c_out_data;
    logic [1:0]  c_out_ch;
    logic        c_out_valid;

    int          n_cmp = 0, n_err = 0;
    int          m_ptr = 3;
    bit          m_ov = 0;
    bit          exp_load = 0;
    logic [3:0]  exp_rdy = '0;
    logic [9:0]  sb[$];

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_stream_mux #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst(c_rst), .mode(c_mode), .sel(c_sel), .in_data(c_in_data),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_ch(c_out_ch), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    // Drive one cycle of stimulus and predict grant/ready; predicted words go to the scoreboard.
    task automatic drive(input logic r, input logic md, input logic [1:0] s,
                         input logic [3:0] v, input logic ordy);
        int idx;
        @(negedge clk);
        rst = r; mode = md; sel = s; in_valid = v; out_ready = ordy;
        idx = -1;
        if (md) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (idx < 0 && v[c]) idx = c;
            end
        end else if (v[s]) idx = int'(s);
        if (r || (m_ov && !ordy)) idx = -1;
        exp_rdy  = '0;
        exp_load = 0;
        if (r) begin
            m_ov = 0; m_ptr = 3;
        end else if (idx >= 0) begin
            exp_rdy[idx] = 1'b1;
            exp_load = 1;
            sb.push_back({2'(idx), in_data[idx*8 +: 8]});
            m_ov = 1;
            if (md) m_ptr = idx;
        end else if (ordy) m_ov = 0;
        #1;
    endtask

    logic       mon_ld;
    logic [9:0] mon_e;
    always @(posedge clk) begin
        mon_ld = exp_load;
        #1;
        if (mon_ld) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: word expected but scoreboard empty");
            end else begin
                mon_e = sb.pop_front();
                if (out_valid !== 1'b1 || out_ch !== mon_e[9:8] || out_data !== mon_e[7:0]) begin
                    n_err++;
                    $display("FAIL sb_word: got v=%0b ch=%0d d=%h, want v=1 ch=%0d d=%h",
                             out_valid, out_ch, out_data, mon_e[9:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 0, 4'hF, 1);
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL rst_ready: got %b want 0000", in_ready);
            end
        end
        @(posedge clk); #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL rst_out: got v=%0b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
        end
        drive(0, 1, 0, 4'hF, 1);
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL rst_first_gnt: got %b want 0001", in_ready);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_rr_fair();
        drive(1, 1, 0, 4'hF, 1);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 4'hF, 1);
            n_cmp++;
            if (in_ready !== 4'(1 << (k % 4))) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % 4)));
            end
            @(posedge clk); #2;
            n_cmp++;
            if (out_valid !== 1'b1 || out_ch !== 2'(k % 4)) begin
                n_err++; $display("FAIL rr_seq[%0d]: got v=%0b ch=%0d want 1/%0d", k, out_valid, out_ch, k % 4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 4'b1010, 1);
            @(posedge clk); #2;
            n_cmp++;
            if (out_ch !== ((k % 2 == 0) ? 2'd1 : 2'd3)) begin
                n_err++; $display("FAIL rr_sparse[%0d]: got ch=%0d want %0d", k, out_ch, (k % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_fixed();
        drive(0, 0, 2, 4'hF, 1);
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL fix_ready: got %b want 0100", in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (out_data !== 8'h22 || out_ch !== 2'd2) begin
            n_err++; $display("FAIL fix_word: got d=%h ch=%0d want 22/2", out_data, out_ch);
        end
        drive(0, 0, 3, 4'b0111, 1);
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL fix_novalid: got %b want 0000", in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL fix_drain: got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        drive(0, 0, 1, 4'hF, 1);
        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1, 4'hF, 0);
            n_cmp++;
            if (in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready);
            end
            @(posedge clk); #2;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%0b d=%h ch=%0d want 1/11/1", k, out_valid, out_data, out_ch);
            end
        end
        drive(0, 0, 2, 4'hF, 1);
        n_cmp++;
        if (in_ready !== 4'b0100) begin
            n_err++; $display("FAIL bp_release: got %b want 0100", in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            n_err++; $display("FAIL bp_next: got v=%0b d=%h want 1/22", out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 3, 4'hF, 1);
        @(posedge clk); #2;
        drive(1, 0, 3, 4'hF, 0);
        n_cmp++;
        if (in_ready !== 4'b0000) begin
            n_err++; $display("FAIL mid_rst_ready: got %b want 0000", in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL mid_rst_out: got v=%0b d=%h ch=%0d want 0/00/0", out_valid, out_data, out_ch);
        end
        drive(0, 1, 0, 4'hF, 1);
        n_cmp++;
        if (in_ready !== 4'b0001) begin
            n_err++; $display("FAIL mid_rst_gnt: got %b want 0001", in_ready);
        end
        @(posedge clk); #2;
        drive(0, 1, 0, 4'h0, 1);
        @(posedge clk); #2;
    endtask

    task automatic test_odd_nch();
        @(negedge clk);
        c_rst = 0; c_mode = 1; c_in_valid = 3'b011; c_out_ready = 1;
        #1;
        n_cmp++;
        if (c_in_ready !== 3'b001) begin
            n_err++; $display("FAIL odd_wrap_ready: got %b want 001", c_in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (c_out_valid !== 1'b1 || c_out_ch !== 2'd0 || c_out_data !== 8'hA0) begin
            n_err++; $display("FAIL odd_first: got v=%0b ch=%0d d=%h want 1/0/a0", c_out_valid, c_out_ch, c_out_data);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (c_in_ready !== 3'b010) begin
            n_err++; $display("FAIL odd_second_ready: got %b want 010", c_in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (c_out_ch !== 2'd1 || c_out_data !== 8'hB1) begin
            n_err++; $display("FAIL odd_second: got ch=%0d d=%h want 1/b1", c_out_ch, c_out_data);
        end
        @(negedge clk);
        c_mode = 0; c_sel = 2'd3; c_in_valid = 3'b111;
        #1;
        n_cmp++;
        if (c_in_ready !== 3'b000) begin
            n_err++; $display("FAIL odd_sel_oob: got %b want 000", c_in_ready);
        end
        @(posedge clk); #2;
        n_cmp++;
        if (c_out_valid !== 1'b0) begin
            n_err++; $display("FAIL odd_oob_drain: got v=%0b want 0", c_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rr_fair();
        test_fixed();
        test_backpressure();
        test_reset_mid();
        test_odd_nch();
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d words want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the team's 4:1 dataflow mux.
- Selects one of NCH channels, each WIDTH bits wide, with valid/ready handshakes on the inputs and on the output.
- Two select modes:
  - fixed: an external select input chooses the channel.
  - round-robin: the block arbitrates fairly between channels.
- The selected word passes through a one-entry output register, so the block sits between stream producers and a single consumer.

Parameters:
- WIDTH, 8, data bits per channel
- NCH, 4, number of input channels (2..16, need not be a power of two)
- SELW, 2, select/index width; must be at least ceil(log2(NCH))

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- out_data  output  WIDTH  registered output word
- out_ch  output  SELW  index of the channel that produced out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer ptr = NCH-1, so channel 0 has highest priority first.
  - in_ready = 0 while rst = 1.
- Load enable: load_en = !out_valid | out_ready. The register accepts a new word when empty, or when its current word drains in the same cycle.
- Grant, fixed mode (mode = 0):
  - gnt = one-hot(sel) if sel < NCH and in_valid[sel] = 1.
  - Otherwise gnt = 0.
  - sel >= NCH never grants.
- Grant, round-robin mode (mode = 1):
  - gnt = the first i with in_valid[i] = 1, searching ptr+1, ptr+2, ... modulo NCH.
  - Wrap-around is required: for ptr = NCH-1 the search starts at channel 0.
- Handshake:
  - in_ready[i] = gnt[i] & load_en & !rst.
  - A transfer from channel i occurs when in_valid[i] & in_ready[i].
  - At most one channel transfers per cycle.
- On a transfer:
  - out_data <= channel data, out_ch <= i, out_valid <= 1.
  - In round-robin mode, ptr <= i.
- ptr changes only on a transfer in round-robin mode. Fixed-mode transfers leave ptr unchanged.
- If out_valid & out_ready and no transfer occurs: out_valid <= 0; out_data and out_ch hold their last values.
- Stall: while out_valid & !out_ready, out_data, out_ch and out_valid hold stable and all in_ready are 0.
- Latency: 1 cycle from input transfer to out_valid. Sustained throughput is one word per cycle when out_ready = 1.
- Simultaneous drain and load: the new word replaces the drained one with no bubble.
- A change of mode or sel takes effect on the next grant evaluation. The word already held in the register is unaffected.
- Reset mid-operation: a held word is discarded and the next cycle shows the reset values.
- Inputs are not registered. in_ready depends combinationally on in_valid, mode, sel, ptr and out_ready. The consumer must not make out_ready depend on in_ready.

Decomposition:
- Shared package rr_stream_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
  - Default WIDTH/NCH constants.
- One sub-module: rr_arbiter.
  - Parameters: NCH, SELW.
  - Inputs: req[NCH], ptr.
  - Outputs: one-hot gnt and binary gnt_idx.
  - Purely combinational. The ptr register stays in rr_stream_mux.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with all in_valid = 1 -> in_ready = 0000, out_valid = 0, out_data = 0x00, out_ch = 0. After release in RR mode, the first grant goes to channel 0.
- Fixed mode: mode = 0, sel = 2, in_valid = 1111, data = {0x33, 0x22, 0x11, 0x00}, out_ready = 1 -> in_ready = 0100; the next cycle shows out_data = 0x22, out_ch = 2. Then sel = 3 with in_valid[3] = 0 -> no transfer, and out_valid falls to 0 one cycle later.
- Round-robin fairness: mode = 1, in_valid = 1111 held, out_ready = 1 for 8 cycles -> out_ch sequence 0, 1, 2, 3, 0, 1, 2, 3 with out_valid continuously 1. Sparse case in_valid = 1010 -> sequence 1, 3, 1, 3.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 with out_data = 0x11 -> out_data, out_ch and out_valid stay constant and in_ready = 0000. On out_ready = 1, the next word loads in that same cycle.
- Wrap and odd NCH: NCH = 3, RR mode, ptr = 2, in_valid = 011 -> channel 0 is granted first, then channel 1. Fixed mode with sel = 3 -> never grants.
- Reset mid-stream: assert rst for one cycle while out_valid = 1 and out_ready = 0 -> the following cycle shows out_valid = 0, out_data = 0, and ptr restarts with channel 0 winning.
